sentence_writer: RTL

- Write-side counterpart of the sentence word reader. Accepts a stream of word IDs over a valid/ready handshake and stores them in a sentence buffer. The buffer is indexed by word position and closed with the 8'hFF end-of-sentence code.
- Range-checks each word and flags overflow. Exposes a registered read port so downstream Viterbi stages, or the bench, can read the stored sentence back.

---
 rtl/sentence_writer_if.sv | 24 ++
 rtl/sentence_writer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sentence_writer_if.sv
// Producer-to-writer word stream: valid/ready handshake
// carrying one word ID per beat plus a last-word flag.
interface sentence_writer_if #(
    parameter int word_num_bit = 8
);
    logic                    in_valid;
    logic [word_num_bit-1:0] in_word;
    logic                    in_last;
    logic                    in_ready;

    modport master (
        output in_valid,
        output in_word,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_word,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/sentence_writer.sv
// Sentence buffer writer: stores range-checked word IDs,
// closes with 8'hFF and exposes a registered read port.
module sentence_writer #(
    parameter int word_num     = 95,
    parameter int word_num_bit = 8,
    parameter int w_bit        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    sentence_writer_if.slave        s_in,
    output logic                    done,
    input  logic                    done_ack,
    output logic [w_bit-1:0]        word_count,
    output logic                    error,
    output logic                    overflow,
    input  logic [w_bit-1:0]        rd_addr,
    output logic [word_num_bit-1:0] rd_data
);
    localparam int DEPTH = 2 ** w_bit;

    localparam logic [word_num_bit-1:0] MAX_WORD =
        word_num_bit'(word_num);
    localparam logic [word_num_bit-1:0] EOS =
        {word_num_bit{1'b1}};
    localparam logic [w_bit-1:0] LAST_SLOT =
        w_bit'(DEPTH - 2);

    typedef enum logic [1:0] {
        FILL,
        TERM,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [w_bit-1:0]        wr_ptr_q, wr_ptr_d;
    logic [w_bit-1:0]        word_count_q, word_count_d;
    logic                    error_q, error_d;
    logic                    overflow_q, overflow_d;
    logic [word_num_bit-1:0] rd_data_q;

    logic [word_num_bit-1:0] mem_q [DEPTH];
    logic                    we;
    logic [w_bit-1:0]        waddr;
    logic [word_num_bit-1:0] wdata;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        word_count_d = word_count_q;
        error_d      = error_q;
        overflow_d   = overflow_q;
        we           = 1'b0;
        waddr        = wr_ptr_q;
        wdata        = s_in.in_word;
        unique case (state_q)
            FILL: begin
                if (s_in.in_valid) begin
                    if (s_in.in_word < MAX_WORD) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (s_in.in_last) begin
                            state_d = TERM;
                        end else if (wr_ptr_q == LAST_SLOT) begin
                            // one slot must remain for the terminator
                            overflow_d = 1'b1;
                            state_d    = TERM;
                        end
                    end else begin
                        error_d = 1'b1;
                        if (s_in.in_last) state_d = TERM;
                    end
                end
            end
            TERM: begin
                we           = 1'b1;
                wdata        = EOS;
                word_count_d = wr_ptr_q;
                state_d      = DONE;
            end
            DONE: begin
                if (done_ack) begin
                    state_d      = FILL;
                    wr_ptr_d     = '0;
                    word_count_d = '0;
                    error_d      = 1'b0;
                    overflow_d   = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            error_q      <= 1'b0;
            overflow_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            word_count_q <= word_count_d;
            error_q      <= error_d;
            overflow_q   <= overflow_d;
            rd_data_q    <= mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst) mem_q[waddr] <= wdata;
    end

    assign s_in.in_ready = (state_q == FILL);
    assign done          = (state_q == DONE);
    assign word_count    = word_count_q;
    assign error         = error_q;
    assign overflow      = overflow_q;
    assign rd_data       = rd_data_q;
endmodule
